// File: rtl/frame_sync_deserializer_if.sv
// -----------------------------------------------------------------------------
// frame_sync_deserializer_if
//
// Bundles the serial input and the framed byte output of the receive-side
// framer.
//
//   bit_in          serial data bit, meaningful only while bit_valid=1
//   bit_valid       qualifies bit_in for one clock cycle
//   data_out        signed payload byte, first received bit in the MSB
//   data_valid      one-cycle strobe, data_out carries a new byte
//   frame_start     one-cycle strobe, marks payload byte 0 of a frame
//   locked          frame alignment confirmed
//   sync_err_count  saturating count of bad sync words seen while verifying
//
// master: the bit source / byte sink side (decoder + downstream DSP, or a bench)
// slave : the framer itself
// -----------------------------------------------------------------------------
interface frame_sync_deserializer_if;
    logic              bit_in;
    logic              bit_valid;
    logic signed [7:0] data_out;
    logic              data_valid;
    logic              frame_start;
    logic              locked;
    logic [15:0]       sync_err_count;

    modport master (
        output bit_in,
        output bit_valid,
        input  data_out,
        input  data_valid,
        input  frame_start,
        input  locked,
        input  sync_err_count
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output data_out,
        output data_valid,
        output frame_start,
        output locked,
        output sync_err_count
    );
endinterface

// File: rtl/frame_sync_deserializer.sv
// -----------------------------------------------------------------------------
// frame_sync_deserializer
//
// Receive-side framer for the serial link. Takes the decoded bit stream from
// the Viterbi decoder, finds frame alignment from an 8-bit sync word sent MSB
// first ahead of every frame, then tracks it with a lock/flywheel scheme and
// emits the payload as signed bytes with a valid strobe.
//
// Ports:
//   clk    bit-domain clock, everything on the rising edge
//   reset  synchronous, active-high; returns every output to 0
//   bus    frame_sync_deserializer_if.slave
//            in : bit_in, bit_valid
//            out: data_out, data_valid, frame_start, locked, sync_err_count
//
// Frame on the wire: SYNC_WORD, then FRAME_LEN payload bytes, repeating.
// Cycles with bit_valid=0 leave all state untouched (strobes simply drop).
// -----------------------------------------------------------------------------
module frame_sync_deserializer #(
    parameter logic [7:0]  SYNC_WORD   = 8'hA7,
    parameter int unsigned FRAME_LEN   = 16,   // 1..255
    parameter int unsigned LOCK_FRAMES = 2,    // 1..15
    parameter int unsigned MISS_MAX    = 3     // 1..15
) (
    input  logic                     clk,
    input  logic                     reset,
    frame_sync_deserializer_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,   // sliding-window search for the sync word
        DATA   = 2'd1,   // collecting payload bytes
        VERIFY = 2'd2    // checking the sync word expected after a frame
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_TGT  = 4'(LOCK_FRAMES);
    localparam logic [3:0] MISS_TGT  = 4'(MISS_MAX);
    localparam logic [3:0] FILL_FULL = 4'd8;
    localparam logic [3:0] CNT_SAT   = 4'd15;
    localparam logic [15:0] ERR_SAT  = 16'hFFFF;

    state_t      state_q,  state_d;
    logic [7:0]  sr_q,     sr_d;      // last 8 accepted bits
    logic [3:0]  fill_q,   fill_d;    // bits accepted since entering HUNT, sat. at 8
    logic [2:0]  bit_q,    bit_d;     // bit position inside the current byte
    logic [7:0]  byte_q,   byte_d;    // payload byte index inside the frame
    logic [3:0]  good_q,   good_d;    // consecutive good sync words
    logic [3:0]  miss_q,   miss_d;    // consecutive bad sync words while locked
    logic [7:0]  data_q,   data_d;
    logic        dv_q,     dv_d;
    logic        fs_q,     fs_d;
    logic        lock_q,   lock_d;
    logic [15:0] err_q,    err_d;

    // Window including the bit being accepted this cycle; all byte and sync
    // decisions look at this so they land on the edge that takes the last bit.
    logic [7:0]  shifted;
    assign shifted = {sr_q[6:0], bus.bit_in};

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d starts from its held value (strobes from 0) before any
        // branch, so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        good_d  = good_q;
        miss_d  = miss_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        lock_d  = lock_q;
        err_d   = err_q;

        if (bus.bit_valid) begin
            sr_d = shifted;

            unique case (state_q)
                HUNT: begin
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 4'd1;
                    end
                    // fill_q >= 7 means this bit is at least the 8th since HUNT began
                    if ((fill_q >= 4'd7) && (shifted == SYNC_WORD)) begin
                        state_d = DATA;
                        good_d  = 4'd1;
                        miss_d  = 4'd0;
                        bit_d   = 3'd0;
                        byte_d  = 8'd0;
                        if (LOCK_TGT == 4'd1) begin
                            lock_d = 1'b1;
                        end
                    end
                end

                DATA: begin
                    bit_d = bit_q + 3'd1;   // wraps 7 -> 0
                    if (bit_q == 3'd7) begin
                        data_d = shifted;
                        dv_d   = 1'b1;
                        fs_d   = (byte_q == 8'd0);
                        if (byte_q == LAST_BYTE) begin
                            byte_d  = 8'd0;
                            state_d = VERIFY;
                        end else begin
                            byte_d = byte_q + 8'd1;
                        end
                    end
                end

                VERIFY: begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (shifted == SYNC_WORD) begin
                            miss_d  = 4'd0;
                            good_d  = (good_q == CNT_SAT) ? CNT_SAT : good_q + 4'd1;
                            if (good_d >= LOCK_TGT) begin
                                lock_d = 1'b1;
                            end
                            state_d = DATA;
                        end else begin
                            if (err_q != ERR_SAT) begin
                                err_d = err_q + 16'd1;
                            end
                            good_d = 4'd0;
                            // Unlocked: the alignment was never confirmed, drop it.
                            // Locked: flywheel through up to MISS_MAX-1 bad words.
                            if (lock_q && ((miss_q + 4'd1) < MISS_TGT)) begin
                                miss_d  = miss_q + 4'd1;
                                state_d = DATA;
                            end else begin
                                lock_d  = 1'b0;
                                state_d = HUNT;
                                fill_d  = 4'd0;
                                bit_d   = 3'd0;
                                byte_d  = 8'd0;
                                miss_d  = 4'd0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                    fill_d  = 4'd0;
                    bit_d   = 3'd0;
                    byte_d  = 8'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge
        // values regardless of statement order.
        if (reset) begin
            state_q <= HUNT;
            sr_q    <= 8'd0;
            fill_q  <= 4'd0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            good_q  <= 4'd0;
            miss_q  <= 4'd0;
            data_q  <= 8'd0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out       = $signed(data_q);
    assign bus.data_valid     = dv_q;
    assign bus.frame_start    = fs_q;
    assign bus.locked         = lock_q;
    assign bus.sync_err_count = err_q;

endmodule

// File: tb/tb_frame_sync_deserializer.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_deserializer
//
// Directed scenarios with randomized fill (gaps, idle bit values, payload) for
// frame_sync_deserializer. A frame-position reference model predicts every
// output on every cycle; directed checks confirm lock timing, error counts
// and byte sequences at the interesting points.
// -----------------------------------------------------------------------------
module tb_frame_sync_deserializer;

    localparam logic [7:0] SYNC  = 8'hA7;
    localparam logic [7:0] BAD   = 8'hA6;
    localparam int         FLEN  = 16;
    localparam int         LOCKF = 2;
    localparam int         MISSM = 3;
    localparam int         FRAME_BITS = FLEN * 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_sync_deserializer_if bus ();

    frame_sync_deserializer #(
        .SYNC_WORD  (SYNC),
        .FRAME_LEN  (FLEN),
        .LOCK_FRAMES(LOCKF),
        .MISS_MAX   (MISSM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    int         fs_cnt;

    // ---------------- reference model ----------------
    // Alignment is tracked as one position within the 8*(FLEN+1)-bit frame
    // period that follows a recognised sync word.
    logic [7:0]  m_window;
    int          m_hunt_bits;
    bit          m_aligned;
    int          m_pos;
    int          m_good, m_miss;
    bit          m_locked;
    int          m_err;
    logic [7:0]  e_data;
    bit          e_dv, e_fs;

    task automatic model_reset();
        m_window = 8'd0; m_hunt_bits = 0; m_aligned = 0; m_pos = 0;
        m_good = 0; m_miss = 0; m_locked = 0; m_err = 0;
        e_data = 8'd0; e_dv = 0; e_fs = 0;
    endtask

    task automatic model_lose();
        m_aligned = 0; m_hunt_bits = 0; m_miss = 0;
    endtask

    task automatic model_bit(input logic b);
        e_dv = 0; e_fs = 0;
        m_window = {m_window[6:0], b};
        if (!m_aligned) begin
            m_hunt_bits++;
            if (m_hunt_bits >= 8 && m_window == SYNC) begin
                m_aligned = 1; m_pos = 0; m_good = 1; m_miss = 0;
                if (LOCKF <= 1) m_locked = 1;
            end
        end else if (m_pos < FRAME_BITS) begin
            if (m_pos % 8 == 7) begin
                e_data = m_window; e_dv = 1; e_fs = (m_pos == 7);
            end
            m_pos++;
        end else if (m_pos < FRAME_BITS + 7) begin
            m_pos++;
        end else begin
            m_pos = 0;
            if (m_window == SYNC) begin
                m_miss = 0;
                m_good = (m_good < 15) ? m_good + 1 : 15;
                if (m_good >= LOCKF) m_locked = 1;
            end else begin
                m_err  = (m_err < 65535) ? m_err + 1 : 65535;
                m_good = 0;
                if (!m_locked) begin
                    model_lose();
                end else begin
                    m_miss++;
                    if (m_miss >= MISSM) begin
                        m_locked = 0;
                        model_lose();
                    end
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        check("data_valid",     32'(bus.data_valid),           32'(e_dv));
        check("frame_start",    32'(bus.frame_start),          32'(e_fs));
        check("data_out",       32'($unsigned(bus.data_out)),  32'(e_data));
        check("locked",         32'(bus.locked),               32'(m_locked));
        check("sync_err_count", 32'(bus.sync_err_count),       32'(m_err));
        if (bus.data_valid)  got_q.push_back($unsigned(bus.data_out));
        if (bus.frame_start) fs_cnt++;
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic cycle(input logic rst, input logic bv, input logic b);
        reset         = rst;
        bus.bit_valid = bv;
        bus.bit_in    = b;
        @(posedge clk);
        if (rst)     model_reset();
        else if (bv) model_bit(b);
        else begin e_dv = 0; e_fs = 0; end
        #1;
        compare_outputs();
    endtask

    task automatic send_bit(input logic b, input int gap_max);
        int idle;
        idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (idle) cycle(1'b0, 1'b0, 1'($urandom));
        cycle(1'b0, 1'b1, b);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_max);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap_max);
    endtask

    task automatic send_payload(input int gap_max);
        for (int j = 0; j < FLEN; j++) send_byte(8'(j), gap_max);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        got_q.delete();
        fs_cnt = 0;
    endtask

    // 8 idle zeros then three A7 frames with payload 00..0F.
    task automatic clean_lock(input int gap_max);
        got_q.delete();
        fs_cnt = 0;
        repeat (8) send_bit(1'b0, gap_max);
        send_byte(SYNC, gap_max);
        send_payload(gap_max);
        check("locked_after_sync1", 32'(bus.locked), 32'd0);
        send_byte(SYNC, gap_max);
        check("locked_after_sync2", 32'(bus.locked), 32'd1);
        send_payload(gap_max);
        send_byte(SYNC, gap_max);
        send_payload(gap_max);
        check("clean_byte_count", 32'(got_q.size()), 32'd48);
        for (int i = 0; i < 48 && i < got_q.size(); i++)
            check("clean_byte_seq", 32'(got_q[i]), 32'(i % 16));
        check("clean_frame_starts", 32'(fs_cnt), 32'd3);
        check("clean_err_count", 32'(bus.sync_err_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        model_reset();
        got_q.delete();
        fs_cnt = 0;

        // ---- reset state ----
        do_reset();
        check("rst_data_out",   32'($unsigned(bus.data_out)), 32'd0);
        check("rst_data_valid", 32'(bus.data_valid),          32'd0);
        check("rst_locked",     32'(bus.locked),              32'd0);
        check("rst_err_count",  32'(bus.sync_err_count),      32'd0);

        // ---- clean lock, contiguous bits ----
        clean_lock(0);

        // ---- flywheel: two bad syncs tolerated, third good one clears misses ----
        got_q.delete();
        send_byte(BAD, 0);
        send_payload(0);
        check("fly_locked_1bad", 32'(bus.locked), 32'd1);
        send_byte(BAD, 0);
        check("fly_locked_2bad", 32'(bus.locked), 32'd1);
        check("fly_err_2bad",    32'(bus.sync_err_count), 32'd2);
        send_payload(0);
        check("fly_byte_count",  32'(got_q.size()), 32'd32);
        for (int i = 0; i < 32 && i < got_q.size(); i++)
            check("fly_byte_seq", 32'(got_q[i]), 32'(i % 16));
        send_byte(SYNC, 0);
        send_payload(0);
        send_byte(BAD, 0);
        check("fly_miss_cleared", 32'(bus.locked), 32'd1);
        check("fly_err_3bad",     32'(bus.sync_err_count), 32'd3);
        send_payload(0);

        // ---- loss of lock after MISS_MAX bad syncs, then relock ----
        do_reset();
        repeat (8) send_bit(1'b0, 0);
        send_byte(SYNC, 0); send_payload(0);
        send_byte(SYNC, 0); send_payload(0);
        check("loss_locked_before", 32'(bus.locked), 32'd1);
        send_byte(BAD, 0); send_payload(0);
        send_byte(BAD, 0); send_payload(0);
        check("loss_locked_2bad", 32'(bus.locked), 32'd1);
        send_byte(BAD, 0);
        check("loss_unlocked_3bad", 32'(bus.locked), 32'd0);
        send_byte(SYNC, 0); send_payload(0);
        check("loss_relock_1good", 32'(bus.locked), 32'd0);
        send_byte(SYNC, 0);
        check("loss_relock_2good", 32'(bus.locked), 32'd1);
        check("loss_err_count",    32'(bus.sync_err_count), 32'd3);
        send_payload(0);

        // ---- false sync in random data (low-nibble bytes cannot contain A7) ----
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom) & 8'h0F, 0);
        send_byte(SYNC, 0);
        for (int i = 0; i < FLEN; i++) send_byte(8'($urandom), 0);
        check("false_payload_out", 32'(got_q.size()), 32'(FLEN));
        send_byte(8'h3C, 0);
        check("false_unlocked",  32'(bus.locked), 32'd0);
        check("false_err_count", 32'(bus.sync_err_count), 32'd1);
        send_byte(SYNC, 0); send_payload(0);
        send_byte(SYNC, 0);
        check("false_relocked",  32'(bus.locked), 32'd1);
        send_payload(0);

        // ---- gapped input: same results as the clean lock ----
        do_reset();
        clean_lock(5);

        // ---- reset mid-frame during payload byte 7 ----
        do_reset();
        repeat (8) send_bit(1'b0, 0);
        send_byte(SYNC, 0); send_payload(0);
        send_byte(SYNC, 0);
        for (int j = 0; j < 7; j++) send_byte(8'(j), 0);
        send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0);
        check("midrst_data_out",    32'($unsigned(bus.data_out)), 32'd0);
        check("midrst_data_valid",  32'(bus.data_valid),          32'd0);
        check("midrst_frame_start", 32'(bus.frame_start),         32'd0);
        check("midrst_locked",      32'(bus.locked),              32'd0);
        check("midrst_err_count",   32'(bus.sync_err_count),      32'd0);
        got_q.delete();
        fs_cnt = 0;
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        for (int j = 8; j < FLEN; j++) send_byte(8'(j), 0);
        check("midrst_no_partial", 32'(got_q.size()), 32'd0);
        send_byte(SYNC, 0); send_payload(0);
        check("midrst_relock_bytes", 32'(got_q.size()), 32'(FLEN));
        if (got_q.size() > 0) check("midrst_first_byte", 32'(got_q[0]), 32'd0);
        check("midrst_frame_start_cnt", 32'(fs_cnt), 32'd1);
        send_byte(SYNC, 0);
        check("midrst_relocked", 32'(bus.locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sync_deserializer.md
# frame_sync_deserializer

Receive-side framer for the serial link. It takes the decoded serial bit stream at the Viterbi decoder output, which uses the framing the transmit-side framer applies in front of the convolutional encoder. It finds and tracks frame alignment from an 8-bit sync word, so the link no longer depends on a fixed pipeline delay. It outputs 8-bit signed samples with a valid strobe to the resampling/DAC path. It runs on the 160 kHz bit clock domain.

## Interface
- SYNC_WORD, 8'hA7, sync pattern transmitted MSB first at the start of every frame
- FRAME_LEN, 16, payload bytes per frame, range 1..255
- LOCK_FRAMES, 2, consecutive good sync words required to assert locked, range 1..15
- MISS_MAX, 3, consecutive bad sync words tolerated while locked before relock, range 1..15
- clk  input  1  bit-domain clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- bit_in  input  1  serial data bit, sampled only when bit_valid=1
- bit_valid  input  1  qualifies bit_in for one cycle
- data_out  output  8  signed payload byte, MSB = first received bit; holds last value between strobes
- data_valid  output  1  one-cycle strobe, data_out is new
- frame_start  output  1  one-cycle strobe, coincident with data_valid of payload byte 0
- locked  output  1  frame alignment confirmed
- sync_err_count  output  16  count of bad sync words seen in VERIFY, saturates at 16'hFFFF

## Operation
- Reset values: data_out=0, data_valid=0, frame_start=0, locked=0, sync_err_count=0. State=HUNT. All counters and shift registers are 0. The fill counter is 0.
- An 8-bit shift register loads bit_in on each accepted bit: sr <= {sr[6:0], bit_in}. Cycles with bit_valid=0 change nothing in the datapath or the FSM.
- A fill counter saturates at 8. HUNT compares only once 8 bits have been accepted since entering HUNT.
- State HUNT: on each accepted bit, compare {sr[6:0],bit_in} to SYNC_WORD.
  - On match, go to DATA, set good_cnt=1 and miss_cnt=0.
  - If LOCK_FRAMES=1, locked is set on this match.
- State DATA: collect FRAME_LEN bytes MSB first.
  - On each 8th bit, register the byte to data_out and pulse data_valid.
  - Pulse frame_start on byte 0.
  - A sync pattern inside the payload is ignored.
  - After byte FRAME_LEN-1, go to VERIFY.
- State VERIFY: collect 8 bits and compare them to SYNC_WORD.
  - Match: miss_cnt=0; good_cnt increments and saturates at 15; locked=1 when good_cnt reaches LOCK_FRAMES; go to DATA.
  - Mismatch: sync_err_count increments (saturating) and good_cnt=0.
    - If locked=0, go to HUNT immediately.
    - If locked=1, miss_cnt increments. If miss_cnt reaches MISS_MAX, clear locked and go to HUNT. Otherwise stay aligned (flywheel) and go to DATA.
- Entering HUNT clears the fill counter, the bit and byte counters, and miss_cnt. data_out is not cleared.
- Payload is output in DATA whether or not locked is set. Downstream logic gates on locked.

## Timing
- data_valid and frame_start go high in the cycle after the clk edge that accepts the last bit of a byte. Latency is 1 cycle from that last bit_valid.
- locked changes in the cycle after the edge accepting the last bit of the deciding sync word. So does sync_err_count.
- Back-to-back bit_valid on every cycle gives one data_valid every 8 cycles and no bubbles between frames.
- Arbitrary gaps in bit_valid only stretch the timing. There are no timeouts.
- A reset asserted in any state or mid-byte takes effect at the next edge and returns every output to its reset value. A partial byte is discarded.
- reset and bit_valid high in the same cycle: reset wins and the bit is dropped.
- The byte counter wraps 0..FRAME_LEN-1. The bit counter wraps 0..7.

## Test plan
- Clean lock: 8 idle zero bits, then 3 frames (A7, payload 00..0F) with contiguous bit_valid.
  - Expect 48 data_valid pulses with data_out matching the payload in sequence.
  - Expect frame_start on each 00.
  - Expect locked rising after the 2nd sync word.
  - Expect sync_err_count=0.
- Flywheel: lock, then corrupt 2 consecutive sync words to 8'hA6.
  - locked stays 1 and payload keeps streaming aligned.
  - sync_err_count=2.
  - A third good sync clears miss_cnt.
- Loss of lock: lock, then corrupt 3 consecutive sync words.
  - locked drops after the 3rd bad sync and the block re-enters HUNT.
  - Then send clean frames: locked returns after 2 good syncs, and sync_err_count=3.
- False sync: while hunting, embed A7 in random data followed by a wrong "sync" 17 bytes later.
  - The block returns to HUNT with locked=0.
  - It then locks correctly on real frames.
- Gapped input: the clean-lock stimulus with bit_valid held low 0–5 random cycles between bits.
  - Expect an identical byte sequence and identical lock behaviour.
- Reset mid-frame: assert reset for 1 cycle during payload byte 7 with bit_valid high.
  - All outputs go to 0 on the next cycle.
  - Relock occurs only on a subsequent full A7, with the partial byte never output.
